mouse_send_byte: RTL and testbench
==================================

# mouse_send_byte

Host-to-device PS/2 transmitter for the mouse driver: sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") from the FPGA to the mouse, the opposite direction of the byte receiver. It performs the PS/2 request-to-send sequence and shifts out 8 data bits LSB-first, odd parity and stop. It then samples the device acknowledge. Pins are open-drain: the block only ever drives a line low or releases it; the top level owns the tristate buffers and shares the lines with the receiver.

## Interface
- CLK_INHIBIT_CYCLES, 5000: cycles the mouse clock is held low before the start bit (100 µs at 50 MHz); must be ≥ 2.
- TIMEOUT_CYCLES, 1000000: maximum cycles without a mouse-clock falling edge while transmitting before abort (20 ms at 50 MHz).
- i_driver_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_byte  in  8  command byte; sampled only on an accepted i_send.
- i_send  in  1  request to transmit; accepted only when o_busy=0.
- o_busy  out  1  high from the cycle after acceptance until return to IDLE.
- i_mouse_clk  in  1  PS/2 clock pin level (asynchronous).
- i_mouse_data  in  1  PS/2 data pin level (asynchronous).
- o_mouse_clk_low  out  1  1 = pull clock line low, 0 = release.
- o_mouse_data_low  out  1  1 = pull data line low, 0 = release.
- o_done  out  1  one-cycle pulse: byte sent and acknowledged (ack bit = 0).
- o_ack_err  out  1  one-cycle pulse: ack bit sampled as 1.
- o_timeout  out  1  one-cycle pulse: transfer aborted on timeout.

## Operation
- Input conditioning: i_mouse_clk and i_mouse_data pass through 2-flop synchronizers. A falling edge (fe) is sync_clk_prev=1 and sync_clk=0. Reset value of the synchronizers is 1.
- Byte and parity latched on acceptance: shift_reg <= i_byte, parity <= ~^i_byte (odd parity).
- States:
  - IDLE: all lines released. On i_send -> INHIBIT, counter cleared.
  - INHIBIT: o_mouse_clk_low=1 for CLK_INHIBIT_CYCLES cycles -> REQ.
  - REQ: o_mouse_clk_low=1 and o_mouse_data_low=1 for exactly 1 cycle (start bit) -> SEND, bit index 0.
  - SEND: o_mouse_clk_low=0. Start bit stays driven until the first fe. On fe number k:
    - k=1..8: drive data bit k-1 (o_mouse_data_low = ~bit).
    - k=9: drive the parity bit.
    - k=10: release data (stop bit = 1) -> ACK.
  - ACK: on the next fe, sample sync_data. 0 -> pulse o_done; 1 -> pulse o_ack_err. Either way -> IDLE.
- Timeout: in SEND and ACK a cycle counter clears on every fe. When it reaches TIMEOUT_CYCLES: release both lines, pulse o_timeout, -> IDLE.
- i_send while o_busy=1 is ignored; no queuing. i_byte changes after acceptance have no effect.
- Only one of o_done/o_ack_err/o_timeout can pulse per transfer.

## Timing
- Reset: state IDLE; o_busy, o_mouse_clk_low, o_mouse_data_low, o_done, o_ack_err, o_timeout all 0; shift_reg 0. Assertion mid-transfer releases both lines immediately (asynchronous), and no completion pulse is issued.
- Acceptance at cycle T: o_busy=1 and o_mouse_clk_low=1 from T+1. The clock is held low for cycles T+1..T+CLK_INHIBIT_CYCLES. o_mouse_data_low rises at T+CLK_INHIBIT_CYCLES+1 together with the last clock-low cycle. The clock is released at T+CLK_INHIBIT_CYCLES+2.
- The data output updates 3 cycles after the pin falling edge: 2 synchronizer stages plus 1 registered output. This is well inside the ≥ 30 µs PS/2 clock-low phase.
- Completion pulses are asserted in the cycle the state returns to IDLE. o_busy=0 in the same cycle. A new i_send is accepted in that cycle.
- Outputs are registered; no combinational path from the pins to the outputs.

## Test plan
Bench parameters: CLK_INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=200. The device model produces a 20-cycle mouse-clock period, samples data on the rising edge, and drives the ack on the 11th falling edge.
- Send 0xF4 with ack=0 -> device sees start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; o_done pulses once; o_busy falls the same cycle.
- Send 0xFF, then 0x00 back-to-back, with ack=0 -> parity 1 for 0xFF and 1 for 0x00; two o_done pulses. The second byte is accepted in the cycle of the first o_done.
- Measure the inhibit sequence after i_send -> o_mouse_clk_low high for exactly 9 cycles; o_mouse_data_low rises on the 9th cycle; no mouse-clock activity is required before release.
- Device returns ack=1 for 0xF4 -> o_ack_err pulses once; o_done stays 0; lines released.
- Device stops clocking after the 4th bit -> o_timeout pulses 200 cycles after the last fe; both lines are released. An i_send pulse while busy is ignored, and i_byte changed mid-transfer does not alter the bits sent.
- Assert rst during SEND -> o_mouse_clk_low and o_mouse_data_low go 0 with no clock edge; no completion pulse. The next send of 0xF4 after reset completes normally.

Source files
------------

// File: rtl/mouse_send_byte.sv
// rtl/mouse_send_byte.sv - PS/2 host-to-device command byte transmitter
//
// Runs the PS/2 request-to-send sequence, then shifts one command byte out to
// the mouse LSB-first with odd parity and stop, and samples the device ack.
// The pin-drive outputs are open-drain requests: 1 pulls the line low and
// 0 releases it. The tristate buffers are instantiated at the top level.
//
// Ports:
//   i_driver_clk      system clock, rising edge
//   rst               asynchronous active-high reset
//   i_byte[7:0]       command byte, captured when i_send is accepted
//   i_send            transmit request, accepted only while o_busy is low
//   o_busy            transfer in progress
//   i_mouse_clk       PS/2 clock pin level (asynchronous)
//   i_mouse_data      PS/2 data pin level (asynchronous)
//   o_mouse_clk_low   1 = pull PS/2 clock low
//   o_mouse_data_low  1 = pull PS/2 data low
//   o_done            1-cycle pulse: byte sent, device acked with 0
//   o_ack_err         1-cycle pulse: device ack bit read as 1
//   o_timeout         1-cycle pulse: device stopped clocking, transfer aborted

module mouse_send_byte #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES     = 1000000
) (
  input  logic       i_driver_clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_send,
  output logic       o_busy,
  input  logic       i_mouse_clk,
  input  logic       i_mouse_data,
  output logic       o_mouse_clk_low,
  output logic       o_mouse_data_low,
  output logic       o_done,
  output logic       o_ack_err,
  output logic       o_timeout
);

  localparam int IW = $clog2(CLK_INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK
  } state_t;

  state_t        state;
  logic          clk_meta;
  logic          sync_clk;
  logic          sync_clk_prev;
  logic          data_meta;
  logic          sync_data;
  logic          fe;
  logic [7:0]    shift_reg;
  logic          parity;
  logic [3:0]    bit_idx;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;

  // Idle PS/2 lines are pulled high, so the synchronizers reset to 1 to avoid
  // a spurious falling edge right after reset.
  always_ff @(posedge i_driver_clk or posedge rst) begin
    if (rst) begin
      clk_meta      <= 1'b1;
      sync_clk      <= 1'b1;
      sync_clk_prev <= 1'b1;
      data_meta     <= 1'b1;
      sync_data     <= 1'b1;
    end else begin
      clk_meta      <= i_mouse_clk;
      sync_clk      <= clk_meta;
      sync_clk_prev <= sync_clk;
      data_meta     <= i_mouse_data;
      sync_data     <= data_meta;
    end
  end

  assign fe = sync_clk_prev & ~sync_clk;

  always_ff @(posedge i_driver_clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      o_busy           <= 1'b0;
      o_mouse_clk_low  <= 1'b0;
      o_mouse_data_low <= 1'b0;
      o_done           <= 1'b0;
      o_ack_err        <= 1'b0;
      o_timeout        <= 1'b0;
      shift_reg        <= 8'h00;
      parity           <= 1'b0;
      bit_idx          <= 4'd0;
      inh_cnt          <= '0;
      tmo_cnt          <= '0;
    end else begin
      o_done    <= 1'b0;
      o_ack_err <= 1'b0;
      o_timeout <= 1'b0;

      case (state)
        IDLE: begin
          o_mouse_clk_low  <= 1'b0;
          o_mouse_data_low <= 1'b0;
          if (i_send) begin
            shift_reg       <= i_byte;
            parity          <= ~^i_byte;
            inh_cnt         <= '0;
            o_busy          <= 1'b1;
            o_mouse_clk_low <= 1'b1;
            state           <= INHIBIT;
          end
        end

        INHIBIT: begin
          // Start bit goes low while the clock is still held for one more
          // cycle, so the device sees data low as soon as the clock releases.
          if (inh_cnt == INH_LAST) begin
            o_mouse_data_low <= 1'b1;
            state            <= REQ;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
          end
        end

        REQ: begin
          o_mouse_clk_low <= 1'b0;
          bit_idx         <= 4'd0;
          tmo_cnt         <= '0;
          state           <= SEND;
        end

        SEND: begin
          if (fe) begin
            tmo_cnt <= '0;
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx < 4'd8) begin
              o_mouse_data_low <= ~shift_reg[0];
              shift_reg        <= {1'b0, shift_reg[7:1]};
            end else if (bit_idx == 4'd8) begin
              o_mouse_data_low <= ~parity;
            end else begin
              // Stop bit is a released (high) line.
              o_mouse_data_low <= 1'b0;
              state            <= ACK;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            o_mouse_clk_low  <= 1'b0;
            o_mouse_data_low <= 1'b0;
            o_busy           <= 1'b0;
            o_timeout        <= 1'b1;
            state            <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ACK: begin
          if (fe) begin
            o_busy <= 1'b0;
            state  <= IDLE;
            if (sync_data) begin
              o_ack_err <= 1'b1;
            end else begin
              o_done <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            o_mouse_clk_low  <= 1'b0;
            o_mouse_data_low <= 1'b0;
            o_busy           <= 1'b0;
            o_timeout        <= 1'b1;
            state            <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: begin
          o_mouse_clk_low  <= 1'b0;
          o_mouse_data_low <= 1'b0;
          o_busy           <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_send_byte.sv
// tb/tb_mouse_send_byte.sv - scoreboard bench for mouse_send_byte with a PS/2 device model

module tb_mouse_send_byte;

  localparam int INH = 8;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_byte;
  logic       i_send;
  logic       o_busy;
  logic       o_clk_low;
  logic       o_data_low;
  logic       o_done;
  logic       o_ack_err;
  logic       o_timeout;
  logic       dev_clk_rel = 1'b1;
  logic       dev_data_rel = 1'b1;
  logic       mouse_clk_pin;
  logic       mouse_data_pin;

  // Open-drain lines: low if either side pulls.
  assign mouse_clk_pin  = dev_clk_rel & ~o_clk_low;
  assign mouse_data_pin = dev_data_rel & ~o_data_low;

  mouse_send_byte #(
    .CLK_INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .i_driver_clk    (clk),
    .rst             (rst),
    .i_byte          (i_byte),
    .i_send          (i_send),
    .o_busy          (o_busy),
    .i_mouse_clk     (mouse_clk_pin),
    .i_mouse_data    (mouse_data_pin),
    .o_mouse_clk_low (o_clk_low),
    .o_mouse_data_low(o_data_low),
    .o_done          (o_done),
    .o_ack_err       (o_ack_err),
    .o_timeout       (o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  int          exp_evt[$];    // 1 = done, 2 = ack_err, 3 = timeout
  logic [10:0] exp_frame[$];  // {stop, parity, data[7:0], start}

  int          dev_mode = 0;  // 0 full frame checked, 1 stall after 4 clocks, 2 full frame unchecked
  logic        dev_ack = 1'b0;
  logic        dev_idle = 1'b1;
  int          last_fall_cyc = 0;
  int          tmo_cyc = -1;
  logic [10:0] dev_fr;
  logic [10:0] dev_exp;
  int          dev_n;
  int          mode_now;
  logic        prev_busy = 1'b0;
  int          ev_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PS/2 device: waits for inhibit then request-to-send, clocks the frame
  // with a 20-cycle period, samples data on rising edges, acks on fall 11.
  initial begin
    forever begin
      @(negedge clk);
      if (o_clk_low) begin
        while (o_clk_low) @(negedge clk);
        if (!rst && mouse_data_pin == 1'b0) begin
          dev_idle = 1'b0;
          mode_now = dev_mode;
          dev_fr   = '0;
          dev_n    = (mode_now == 1) ? 4 : 11;
          repeat (5) @(negedge clk);
          dev_fr[0] = mouse_data_pin;
          for (int k = 1; k <= dev_n; k++) begin
            dev_clk_rel   = 1'b0;
            last_fall_cyc = cyc;
            if (k == 11) dev_data_rel = dev_ack;
            repeat (10) @(negedge clk);
            dev_clk_rel = 1'b1;
            if (k <= 10) dev_fr[k] = mouse_data_pin;
            if (k == 11) dev_data_rel = 1'b1;
            if (k < 11) repeat (10) @(negedge clk);
          end
          if (mode_now != 2) begin
            if (exp_frame.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame_unexpected: got %0h expected none", dev_fr);
            end else begin
              dev_exp = exp_frame.pop_front();
              if (mode_now == 1) check("frame_partial", dev_fr[4:0], dev_exp[4:0]);
              else               check("frame", dev_fr, dev_exp);
            end
          end
          dev_idle = 1'b1;
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (o_done | o_ack_err | o_timeout) begin
        ev_code = o_done ? 1 : (o_ack_err ? 2 : 3);
        check("single_pulse", 32'(o_done) + 32'(o_ack_err) + 32'(o_timeout), 1);
        check("busy_low_at_end", o_busy, 0);
        check("busy_high_before_end", prev_busy, 1);
        check("lines_released_at_end", {o_clk_low, o_data_low}, 0);
        if (o_timeout) tmo_cyc = cyc;
        if (exp_evt.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL event_unexpected: got code %0d expected none", ev_code);
        end else begin
          check("event_code", ev_code, exp_evt.pop_front());
        end
      end
      prev_busy = o_busy;
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got no end of test expected end before time limit");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_byte = b;
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_evt.size() != 0 || exp_frame.size() != 0 || !dev_idle) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, (exp_evt.size() == 0 && exp_frame.size() == 0 && dev_idle), 1);
  endtask

  int low_cnt;
  int data_first;
  int n_wait;

  initial begin
    rst    = 1'b1;
    i_send = 1'b0;
    i_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_lines", {o_clk_low, o_data_low}, 0);
    check("rst_pulses", {o_done, o_ack_err, o_timeout}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xF4, ack 0, with inhibit sequence measurement
    dev_mode = 0;
    dev_ack  = 1'b0;
    exp_frame.push_back(11'h5E8);
    exp_evt.push_back(1);
    send(8'hF4);
    check("accept_busy", o_busy, 1);
    low_cnt    = 0;
    data_first = 0;
    for (int i = 1; i <= 12; i++) begin
      if (o_clk_low) low_cnt++;
      if (o_data_low && data_first == 0) data_first = i;
      if (i == 10) begin
        check("clk_released_t10", o_clk_low, 0);
        check("start_bit_held_t10", o_data_low, 1);
      end
      @(negedge clk);
    end
    check("inhibit_low_cycles", low_cnt, 9);
    check("data_low_first_cycle", data_first, 9);
    wait_done("f4");

    // 0xFF then 0x00 back-to-back
    exp_frame.push_back(11'h7FE);
    exp_frame.push_back(11'h600);
    exp_evt.push_back(1);
    exp_evt.push_back(1);
    send(8'hFF);
    n_wait = 0;
    while (!o_done && n_wait < 3000) begin
      @(negedge clk);
      n_wait++;
    end
    check("first_done_seen", o_done, 1);
    i_byte = 8'h00;
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    check("b2b_accepted", o_busy, 1);
    check("b2b_clk_low", o_clk_low, 1);
    wait_done("b2b");

    // ack = 1
    dev_ack = 1'b1;
    exp_frame.push_back(11'h5E8);
    exp_evt.push_back(2);
    send(8'hF4);
    wait_done("ack_err");
    check("ack_err_lines_released", {o_clk_low, o_data_low}, 0);
    dev_ack = 1'b0;
    repeat (5) @(negedge clk);

    // device stalls after 4 bits; i_send and i_byte poked mid-transfer
    dev_mode = 1;
    exp_frame.push_back(11'h008);
    exp_evt.push_back(3);
    send(8'hF4);
    repeat (58) @(negedge clk);
    i_byte = 8'h0B;
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    check("busy_during_ignored_send", o_busy, 1);
    wait_done("timeout");
    check("timeout_delay_window",
          ((tmo_cyc - last_fall_cyc) >= TMO && (tmo_cyc - last_fall_cyc) <= TMO + 4), 1);
    repeat (5) @(negedge clk);
    check("no_queued_send_busy", o_busy, 0);
    check("no_queued_send_lines", {o_clk_low, o_data_low}, 0);

    // reset in SEND
    dev_mode = 2;
    send(8'hF4);
    repeat (28) @(negedge clk);
    check("pre_reset_data_low", o_data_low, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_lines", {o_clk_low, o_data_low}, 0);
    check("async_rst_busy", o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    n_wait = 0;
    while (!dev_idle && n_wait < 1000) begin
      @(negedge clk);
      n_wait++;
    end
    check("device_idle_after_reset", dev_idle, 1);
    repeat (10) @(negedge clk);
    dev_mode = 0;
    exp_frame.push_back(11'h5E8);
    exp_evt.push_back(1);
    send(8'hF4);
    wait_done("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
